// File: rtl/dram_pkg.sv
// Shared types and defaults for the multiplexed-address DRAM responder.
package dram_pkg;

  localparam int unsigned DEF_ADDR_W = 12;
  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StRowOpen,
    StColRead,
    StColWrite,
    StCbr
  } state_e;

  typedef enum logic [1:0] {
    EdgeNone,
    EdgeFall,
    EdgeRise
  } edge_e;

  // prev_q is the registered copy of the strobe, cur is the live pin.
  function automatic edge_e detect_edge(input logic prev_q, input logic cur);
    if (prev_q && !cur) return EdgeFall;
    if (!prev_q && cur) return EdgeRise;
    return EdgeNone;
  endfunction

endpackage

// File: rtl/dram_responder_if.sv
// Controller-side DRAM pin bundle plus the responder status outputs.
interface dram_responder_if
  import dram_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) ();

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_ras_;
  logic              ram_cas_;
  logic              ram_we_;
  logic [DATA_W-1:0] dq_in;
  logic [DATA_W-1:0] dq_out;
  logic              dq_oe;
  logic              refresh_err;
  logic              proto_err;
  logic [15:0]       cbr_count;
  logic [7:0]        viol_count;

  modport master (
    output ram_addr, ram_ras_, ram_cas_, ram_we_, dq_in,
    input  dq_out, dq_oe, refresh_err, proto_err, cbr_count, viol_count
  );

  modport slave (
    input  ram_addr, ram_ras_, ram_cas_, ram_we_, dq_in,
    output dq_out, dq_oe, refresh_err, proto_err, cbr_count, viol_count
  );

endinterface

// File: rtl/dram_timing_check.sv
// RAS-low and RAS-precharge width checker with a saturating violation counter.
module dram_timing_check
  import dram_pkg::*;
#(
  parameter int unsigned T_RAS_MIN = 5,
  parameter int unsigned T_RP_MIN  = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  edge_e      i_ras_edge,
  input  logic       i_ras_pin,
  output logic [7:0] o_viol_count
);

  localparam int unsigned T_MAX = (T_RAS_MIN > T_RP_MIN) ? T_RAS_MIN : T_RP_MIN;
  localparam int unsigned CW    = $clog2(T_MAX + 1);

  logic [CW-1:0] r_low_cnt;
  logic [CW-1:0] r_pre_cnt;
  logic          r_armed;
  logic [7:0]    r_viol_count;
  logic          w_viol;

  // No precharge history exists before the first fall after reset.
  assign w_viol = ((i_ras_edge == EdgeFall) && r_armed && (r_pre_cnt < CW'(T_RP_MIN))) ||
                  ((i_ras_edge == EdgeRise) && (r_low_cnt < CW'(T_RAS_MIN)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_low_cnt    <= '0;
      r_pre_cnt    <= '0;
      r_armed      <= 1'b0;
      r_viol_count <= '0;
    end else begin
      case (i_ras_edge)
        EdgeFall: begin
          r_low_cnt <= CW'(1);
          r_armed   <= 1'b1;
        end
        EdgeRise: begin
          r_pre_cnt <= CW'(1);
        end
        default: begin
          if (!i_ras_pin) begin
            if (r_low_cnt < CW'(T_RAS_MIN)) r_low_cnt <= r_low_cnt + CW'(1);
          end else begin
            if (r_pre_cnt < CW'(T_RP_MIN)) r_pre_cnt <= r_pre_cnt + CW'(1);
          end
        end
      endcase
      if (w_viol && (r_viol_count != 8'hFF)) r_viol_count <= r_viol_count + 8'd1;
    end
  end

  assign o_viol_count = r_viol_count;

endmodule

// File: rtl/dram_responder.sv
// TMS4464-style DRAM responder: page-mode read/write, CBR refresh tracking, protocol flags.
// Define DRAM_TIMING_CHECK_EN to enable RAS width/precharge checking into viol_count.
module dram_responder
  import dram_pkg::*;
#(
  parameter int unsigned ROW_BITS    = 4,
  parameter int unsigned COL_BITS    = 12,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned REFRESH_MAX = 800,
  parameter int unsigned T_RAS_MIN   = 5,
  parameter int unsigned T_RP_MIN    = 5
) (
  input logic             clk,
  input logic             rst_n,
  dram_responder_if.slave bus
);

  localparam int unsigned MEM_AW = ROW_BITS + COL_BITS;
  localparam int unsigned TW     = $clog2(REFRESH_MAX + 1);
  localparam logic [TW-1:0] REF_MAX = TW'(REFRESH_MAX);

  if (ROW_BITS > ADDR_W || COL_BITS > ADDR_W || T_RAS_MIN == 0 || T_RP_MIN == 0 ||
      REFRESH_MAX < 2) begin : g_param_check
    $error("dram_responder: illegal parameter set");
  end

  state_e            r_state;
  logic              r_ras_q;
  logic              r_cas_q;
  logic [ROW_BITS-1:0] r_row;
  logic [DATA_W-1:0] r_dq_out;
  logic              r_dq_oe;
  logic              r_proto_err;
  logic              r_refresh_err;
  logic [15:0]       r_cbr_count;
  logic [TW-1:0]     r_ref_timer;
  logic              r_ref_armed;
  logic [DATA_W-1:0] r_mem [2**MEM_AW];

  edge_e             w_ras_edge;
  edge_e             w_cas_edge;
  logic              w_col_strobe;
  logic [MEM_AW-1:0] w_mem_addr;
  logic [7:0]        w_viol_count;

  assign w_ras_edge   = detect_edge(r_ras_q, bus.ram_ras_);
  assign w_cas_edge   = detect_edge(r_cas_q, bus.ram_cas_);
  // RAS rise wins over a coincident CAS fall in an open row.
  assign w_col_strobe = (r_state == StRowOpen) && (w_ras_edge != EdgeRise) &&
                        (w_cas_edge == EdgeFall);
  assign w_mem_addr   = {r_row, bus.ram_addr[COL_BITS-1:0]};

  always_ff @(posedge clk) begin
    if (w_col_strobe && !bus.ram_we_) r_mem[w_mem_addr] <= bus.dq_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ras_q       <= 1'b1;
      r_cas_q       <= 1'b1;
      r_state       <= StIdle;
      r_row         <= '0;
      r_dq_out      <= '0;
      r_dq_oe       <= 1'b0;
      r_proto_err   <= 1'b0;
      r_refresh_err <= 1'b0;
      r_cbr_count   <= '0;
      r_ref_timer   <= '0;
      r_ref_armed   <= 1'b0;
    end else begin
      r_ras_q <= bus.ram_ras_;
      r_cas_q <= bus.ram_cas_;

      if (r_ref_armed && (r_ref_timer != REF_MAX)) begin
        r_ref_timer <= r_ref_timer + TW'(1);
        if (r_ref_timer == REF_MAX - TW'(1)) r_refresh_err <= 1'b1;
      end

      case (r_state)
        StIdle: begin
          if (w_ras_edge == EdgeFall) begin
            if (w_cas_edge == EdgeFall) begin
              // Simultaneous strobes: open the row but do not honour this CAS.
              r_proto_err <= 1'b1;
              r_row       <= bus.ram_addr[ROW_BITS-1:0];
              r_state     <= StRowOpen;
            end else if (!r_cas_q) begin
              r_state     <= StCbr;
              r_cbr_count <= r_cbr_count + 16'd1;
              r_ref_timer <= '0;
              r_ref_armed <= 1'b1;
            end else begin
              r_row   <= bus.ram_addr[ROW_BITS-1:0];
              r_state <= StRowOpen;
            end
          end
        end
        StRowOpen: begin
          if (w_ras_edge == EdgeRise) begin
            r_state <= StIdle;
            r_dq_oe <= 1'b0;
          end else if (w_col_strobe) begin
            if (!bus.ram_we_) begin
              r_state <= StColWrite;
            end else begin
              r_state  <= StColRead;
              r_dq_out <= r_mem[w_mem_addr];
              r_dq_oe  <= 1'b1;
            end
          end
        end
        StColRead, StColWrite: begin
          if (w_ras_edge == EdgeRise) begin
            r_state <= StIdle;
            r_dq_oe <= 1'b0;
          end else if (w_cas_edge == EdgeRise) begin
            r_state <= StRowOpen;
            r_dq_oe <= 1'b0;
          end
        end
        StCbr: begin
          if (w_ras_edge == EdgeRise) begin
            r_state <= StIdle;
            r_dq_oe <= 1'b0;
          end
        end
        default: begin
          r_state <= StIdle;
          r_dq_oe <= 1'b0;
        end
      endcase
    end
  end

`ifdef DRAM_TIMING_CHECK_EN
  dram_timing_check #(
    .T_RAS_MIN (T_RAS_MIN),
    .T_RP_MIN  (T_RP_MIN)
  ) u_timing_check (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_ras_edge   (w_ras_edge),
    .i_ras_pin    (bus.ram_ras_),
    .o_viol_count (w_viol_count)
  );
`else
  assign w_viol_count = '0;
`endif

  assign bus.dq_out      = r_dq_out;
  assign bus.dq_oe       = r_dq_oe;
  assign bus.refresh_err = r_refresh_err;
  assign bus.proto_err   = r_proto_err;
  assign bus.cbr_count   = r_cbr_count;
  assign bus.viol_count  = w_viol_count;

endmodule

// File: tb/tb_dram_responder.sv
// Self-checking bench for dram_responder: vector table plus read-data scoreboard.
module tb_dram_responder;

  logic clk;
  logic rst_n;

  dram_responder_if #(.ADDR_W(12), .DATA_W(8)) bus ();

  dram_responder #(
    .ROW_BITS    (4),
    .COL_BITS    (12),
    .ADDR_W      (12),
    .DATA_W      (8),
    .REFRESH_MAX (800),
    .T_RAS_MIN   (5),
    .T_RP_MIN    (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [11:0] row;
    logic [11:0] col;
    logic [7:0]  data;
  } vec_t;

  int         n_vec;
  int         n_miss;
  logic       prev_oe;
  bit         oe_seen;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock; pops the scoreboard on every rising dq_oe.
  task automatic tick();
    logic [7:0] e;
    @(posedge clk);
    #1;
    if (bus.dq_oe && !prev_oe) begin
      oe_seen = 1'b1;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_read: got dq_out 0x%0h, expected no read at %0t",
                 bus.dq_out, $time);
      end else begin
        e = exp_q.pop_front();
        check("read_data", {24'd0, bus.dq_out}, {24'd0, e});
      end
    end
    prev_oe = bus.dq_oe;
  endtask

  task automatic access(input logic wr, input logic [11:0] row, input logic [11:0] col,
                        input logic [7:0] data);
    bus.ram_addr = row;
    bus.ram_ras_ = 1'b0;
    tick();
    bus.ram_addr = col;
    bus.ram_we_  = ~wr;
    bus.dq_in    = wr ? data : 8'hFF;
    bus.ram_cas_ = 1'b0;
    if (!wr) exp_q.push_back(data);
    tick();
    if (wr) check("wr_oe_low", {31'd0, bus.dq_oe}, 32'd0);
    else    check("rd_oe_latency", {31'd0, bus.dq_oe}, 32'd1);
    // late WE while CAS is low must not write
    bus.ram_we_ = 1'b0;
    bus.dq_in   = 8'hFF;
    tick();
    bus.ram_we_  = 1'b1;
    bus.ram_cas_ = 1'b1;
    tick();
    check("oe_drop", {31'd0, bus.dq_oe}, 32'd0);
    bus.ram_ras_ = 1'b1;
    tick();
    tick();
  endtask

  task automatic cbr();
    bus.ram_cas_ = 1'b0;
    tick();
    bus.ram_ras_ = 1'b0;
    tick();
    repeat (4) tick();
    bus.ram_ras_ = 1'b1;
    bus.ram_cas_ = 1'b1;
    tick();
    repeat (5) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.ram_ras_ = 1'b1;
    bus.ram_cas_ = 1'b1;
    bus.ram_we_  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    prev_oe = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[11];
    logic [31:0] exp_viol;

    vecs[0]  = '{1'b1, 12'hAB3, 12'h0A5, 8'h5C};
    vecs[1]  = '{1'b0, 12'h003, 12'h0A5, 8'h5C};
    vecs[2]  = '{1'b1, 12'h01C, 12'hFFF, 8'hA7};
    vecs[3]  = '{1'b1, 12'h000, 12'h000, 8'h01};
    vecs[4]  = '{1'b0, 12'hF0C, 12'hFFF, 8'hA7};
    vecs[5]  = '{1'b0, 12'h010, 12'h000, 8'h01};
    vecs[6]  = '{1'b1, 12'h003, 12'h0A6, 8'hE4};
    vecs[7]  = '{1'b0, 12'h003, 12'h0A5, 8'h5C};
    vecs[8]  = '{1'b0, 12'h003, 12'h0A6, 8'hE4};
    vecs[9]  = '{1'b1, 12'h003, 12'h0A5, 8'h99};
    vecs[10] = '{1'b0, 12'h003, 12'h0A5, 8'h99};

    n_vec    = 0;
    n_miss   = 0;
    prev_oe  = 1'b0;
    oe_seen  = 1'b0;
    bus.ram_addr = '0;
    bus.dq_in    = '0;
    do_reset();

    check("rst_dq_oe", {31'd0, bus.dq_oe}, 32'd0);
    check("rst_dq_out", {24'd0, bus.dq_out}, 32'd0);
    check("rst_refresh_err", {31'd0, bus.refresh_err}, 32'd0);
    check("rst_proto_err", {31'd0, bus.proto_err}, 32'd0);
    check("rst_cbr_count", {16'd0, bus.cbr_count}, 32'd0);
    check("rst_viol_count", {24'd0, bus.viol_count}, 32'd0);

    repeat (8) cbr();
    check("cbr_count_8", {16'd0, bus.cbr_count}, 32'd8);
    check("cbr_refresh_err", {31'd0, bus.refresh_err}, 32'd0);
    check("cbr_no_oe", {31'd0, oe_seen}, 32'd0);

    for (int i = 0; i < 11; i++) access(vecs[i].wr, vecs[i].row, vecs[i].col, vecs[i].data);

    // Page mode: two writes then two reads in single RAS cycles.
    bus.ram_addr = 12'h005;
    bus.ram_ras_ = 1'b0;
    tick();
    for (int i = 1; i <= 2; i++) begin
      bus.ram_addr = 12'(i);
      bus.ram_we_  = 1'b0;
      bus.dq_in    = 8'(i * 8'h11);
      bus.ram_cas_ = 1'b0;
      tick();
      bus.ram_we_  = 1'b1;
      bus.ram_cas_ = 1'b1;
      tick();
    end
    bus.ram_ras_ = 1'b1;
    tick();
    tick();
    bus.ram_addr = 12'h005;
    bus.ram_ras_ = 1'b0;
    tick();
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    for (int i = 1; i <= 2; i++) begin
      bus.ram_addr = 12'(i);
      bus.ram_cas_ = 1'b0;
      tick();
      check("page_oe_high", {31'd0, bus.dq_oe}, 32'd1);
      bus.ram_cas_ = 1'b1;
      tick();
      check("page_oe_low", {31'd0, bus.dq_oe}, 32'd0);
    end
    bus.ram_ras_ = 1'b1;
    tick();
    tick();

    // Simultaneous RAS/CAS fall: flagged, no write, later CAS cycle works.
    access(1'b1, 12'h007, 12'h007, 8'h3C);
    check("proto_before", {31'd0, bus.proto_err}, 32'd0);
    bus.ram_addr = 12'h007;
    bus.ram_we_  = 1'b0;
    bus.dq_in    = 8'hEE;
    bus.ram_ras_ = 1'b0;
    bus.ram_cas_ = 1'b0;
    tick();
    check("proto_set", {31'd0, bus.proto_err}, 32'd1);
    tick();
    bus.ram_we_  = 1'b1;
    bus.ram_cas_ = 1'b1;
    tick();
    check("proto_no_oe", {31'd0, bus.dq_oe}, 32'd0);
    bus.ram_cas_ = 1'b0;
    exp_q.push_back(8'h3C);
    tick();
    check("proto_recover_oe", {31'd0, bus.dq_oe}, 32'd1);
    bus.ram_cas_ = 1'b1;
    tick();
    bus.ram_ras_ = 1'b1;
    tick();
    tick();
    check("proto_sticky", {31'd0, bus.proto_err}, 32'd1);
    access(1'b0, 12'h007, 12'h007, 8'h3C);

    // Async reset in the middle of a read; memory keeps its contents.
    access(1'b1, 12'h005, 12'h123, 8'h6B);
    bus.ram_addr = 12'h005;
    bus.ram_ras_ = 1'b0;
    tick();
    bus.ram_addr = 12'h123;
    bus.ram_cas_ = 1'b0;
    exp_q.push_back(8'h6B);
    tick();
    check("pre_rst_oe", {31'd0, bus.dq_oe}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_oe", {31'd0, bus.dq_oe}, 32'd0);
    check("async_rst_dq", {24'd0, bus.dq_out}, 32'd0);
    check("async_rst_proto", {31'd0, bus.proto_err}, 32'd0);
    check("async_rst_cbr", {16'd0, bus.cbr_count}, 32'd0);
    bus.ram_ras_ = 1'b1;
    bus.ram_cas_ = 1'b1;
    @(negedge clk);
    rst_n   = 1'b1;
    prev_oe = 1'b0;
    tick();
    access(1'b0, 12'h005, 12'h123, 8'h6B);

    // Refresh deadline: CBR, then 800 cycles without one.
    cbr();
    repeat (789) tick();
    check("refresh_799", {31'd0, bus.refresh_err}, 32'd0);
    tick();
    check("refresh_800", {31'd0, bus.refresh_err}, 32'd1);
    repeat (20) tick();
    check("refresh_stays", {31'd0, bus.refresh_err}, 32'd1);
    cbr();
    check("refresh_sticky_cbr", {31'd0, bus.refresh_err}, 32'd1);
    check("cbr_count_after", {16'd0, bus.cbr_count}, 32'd2);

    // Short RAS low followed by short precharge.
    do_reset();
    bus.ram_addr = 12'h001;
    bus.ram_ras_ = 1'b0;
    repeat (3) tick();
    bus.ram_ras_ = 1'b1;
    repeat (2) tick();
    bus.ram_ras_ = 1'b0;
    repeat (5) tick();
    bus.ram_ras_ = 1'b1;
    repeat (6) tick();
`ifdef DRAM_TIMING_CHECK_EN
    exp_viol = 32'd2;
`else
    exp_viol = 32'd0;
`endif
    check("viol_count", {24'd0, bus.viol_count}, exp_viol);

    check("pending_reads", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
